// File: rtl/instr_encoder.sv
// Instruction encoder: packs source instruction beats into program words, buffers
// them in a small FIFO and streams them to program memory at consecutive addresses.
module instr_encoder #(
  parameter int PROGRAM_DataWidth = 16,
  parameter int PC_WIDTH          = 8,
  parameter int NumOpCodeBits     = 5,
  parameter int SEL_WIDTH         = 2,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          start_adr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NumOpCodeBits-1:0]     in_opcode,
  input  logic [SEL_WIDTH-1:0]         in_op1,
  input  logic [SEL_WIDTH-1:0]         in_op2,
  input  logic [PC_WIDTH-1:0]          in_literal,
  input  logic                         in_last,
  output logic                         mem_wr_en,
  input  logic                         mem_ready,
  output logic [PC_WIDTH-1:0]          mem_adr,
  output logic [PROGRAM_DataWidth-1:0] mem_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err_opcode,
  output logic                         overflow,
  output logic [PC_WIDTH:0]            word_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state;
  logic [PROGRAM_DataWidth-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic [PC_WIDTH-1:0]          pc;
  logic [PROGRAM_DataWidth:0]   enc_p0;
  logic [PROGRAM_DataWidth-1:0] enc_word_p0;
  logic                         enc_vld_p0;
  logic                         full, empty, accept, enq, deq, wr_done;

  // Returns {supported, word}; unused fields of each format stay zero.
  function automatic logic [PROGRAM_DataWidth:0] encode(
    input logic [NumOpCodeBits-1:0] opc,
    input logic [SEL_WIDTH-1:0]     op1,
    input logic [SEL_WIDTH-1:0]     op2,
    input logic [PC_WIDTH-1:0]      lit
  );
    logic [PROGRAM_DataWidth-1:0] w;
    logic                         ok;
    w  = '0;
    ok = 1'b1;
    case (int'(opc))
      0: w = '0;
      1, 2, 3, 4, 5, 6: begin
        w[PROGRAM_DataWidth-1 -: NumOpCodeBits] = opc;
        w[8 +: SEL_WIDTH] = op1;
        w[3 +: SEL_WIDTH] = op2;
      end
      7, 8, 9, 17, 18: begin
        w[PROGRAM_DataWidth-1 -: NumOpCodeBits] = opc;
        w[8 +: SEL_WIDTH] = op1;
        w[0 +: PC_WIDTH]  = lit;
      end
      16: begin
        w[PROGRAM_DataWidth-1 -: NumOpCodeBits] = opc;
        w[0 +: PC_WIDTH] = lit;
      end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Stage p0: encode the offered beat combinationally; it lands in the FIFO at the edge
  always_comb begin
    enc_p0      = encode(in_opcode, in_op1, in_op2, in_literal);
    enc_vld_p0  = enc_p0[PROGRAM_DataWidth];
    enc_word_p0 = enc_p0[PROGRAM_DataWidth-1:0];
  end

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign in_ready  = (state == RUN) && !full;
  assign accept    = in_valid && in_ready;
  assign enq       = accept && enc_vld_p0;
  assign mem_wr_en = !empty && !overflow;
  assign wr_done   = mem_wr_en && mem_ready;
  // After overflow the head is discarded every cycle regardless of mem_ready.
  assign deq       = !empty && (overflow || mem_ready);
  assign mem_adr   = pc;
  assign mem_data  = empty ? '0 : fifo_mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= enc_word_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pc         <= '0;
      word_count <= '0;
      err_opcode <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_done) begin
        pc         <= pc + 1'b1;
        word_count <= word_count + 1'b1;
        if (pc == '1) overflow <= 1'b1;
      end
      if (accept && !enc_vld_p0) err_opcode <= 1'b1;
      if (enq) wr_ptr <= bump(wr_ptr);
      if (deq) rd_ptr <= bump(rd_ptr);
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          pc         <= start_adr;
          word_count <= '0;
          err_opcode <= 1'b0;
          overflow   <= 1'b0;
        end
        RUN:     if (accept && in_last) state <= DRAIN;
        DRAIN:   if (empty) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: reset checks, encoding table, directed corner sessions
// and randomized sessions checked against a write-list reference model.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0;
  logic [7:0]  start_adr = 8'h00;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [4:0]  in_opcode = 5'd0;
  logic [1:0]  in_op1 = 2'd0, in_op2 = 2'd0;
  logic [7:0]  in_literal = 8'h00;
  logic        mem_wr_en, mem_ready = 1'b0;
  logic [7:0]  mem_adr;
  logic [15:0] mem_data;
  logic        busy, done, err_opcode, overflow;
  logic [8:0]  word_count;

  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .start_adr(start_adr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_op1(in_op1), .in_op2(in_op2), .in_literal(in_literal), .in_last(in_last),
    .mem_wr_en(mem_wr_en), .mem_ready(mem_ready), .mem_adr(mem_adr), .mem_data(mem_data),
    .busy(busy), .done(done), .err_opcode(err_opcode), .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  localparam int LIMIT = 300;
  int n_tests = 0, n_fail = 0;
  int rdy_mode = 0;
  logic rdy_force = 1'b0;
  logic [7:0]  obs_adr[$];
  logic [15:0] obs_data[$];
  int done_cnt = 0, acc_cnt = 0;
  logic [4:0] b_opc[16];
  logic [1:0] b_op1[16], b_op2[16];
  logic [7:0] b_lit[16];

  typedef struct {
    logic [7:0]  sa;
    logic [4:0]  opc;
    logic [1:0]  op1, op2;
    logic [7:0]  lit;
    logic        ok;
    logic [15:0] w;
  } vec_t;
  vec_t vt[15];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ($urandom_range(0, 3) != 0);
      default: mem_ready = rdy_force;
    endcase
  end

  always @(negedge clk) begin
    if (mem_wr_en && mem_ready) begin
      obs_adr.push_back(mem_adr);
      obs_data.push_back(mem_data);
    end
    if (done) done_cnt++;
    if (in_valid && in_ready) acc_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding from the field rules, as plain arithmetic.
  function automatic void model(input int opc, input int op1, input int op2, input int lit,
                                output bit ok, output int w);
    ok = 1'b1;
    w  = 0;
    if (opc == 0) w = 0;
    else if (opc >= 1 && opc <= 6) w = opc * 2048 + op1 * 256 + op2 * 8;
    else if (opc == 7 || opc == 8 || opc == 9 || opc == 17 || opc == 18)
      w = opc * 2048 + op1 * 256 + lit;
    else if (opc == 16) w = opc * 2048 + lit;
    else ok = 1'b0;
  endfunction

  task automatic drive_beat(input int i, input bit last, input bit gaps);
    int c;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_opcode = b_opc[i]; in_op1 = b_op1[i]; in_op2 = b_op2[i];
    in_literal = b_lit[i]; in_last = last;
    c = 0;
    do begin @(negedge clk); c++; end while (!in_ready && c < LIMIT);
    if (!in_ready) chk("beat_accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    do begin @(negedge clk); c++; end while (!done && c < LIMIT);
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic run_session(input logic [7:0] sadr, input int n, input bit gaps);
    logic [7:0]  e_adr[$];
    logic [15:0] e_data[$];
    int adr, w;
    bit ovf, err, ok;
    adr = int'(sadr); ovf = 1'b0; err = 1'b0;
    for (int i = 0; i < n; i++) begin
      model(int'(b_opc[i]), int'(b_op1[i]), int'(b_op2[i]), int'(b_lit[i]), ok, w);
      if (!ok) err = 1'b1;
      else if (!ovf) begin
        e_adr.push_back(8'(adr));
        e_data.push_back(16'(w));
        if (adr == 255) ovf = 1'b1;
        adr = (adr + 1) % 256;
      end
    end
    obs_adr.delete(); obs_data.delete(); done_cnt = 0; acc_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; start_adr = sadr;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) drive_beat(i, i == n - 1, gaps);
    wait_done();
    chk("write_count", 32'(obs_adr.size()), 32'(e_adr.size()));
    for (int i = 0; i < e_adr.size() && i < obs_adr.size(); i++) begin
      chk("write_adr", 32'(obs_adr[i]), 32'(e_adr[i]));
      chk("write_data", 32'(obs_data[i]), 32'(e_data[i]));
    end
    chk("word_count", 32'(word_count), 32'(e_adr.size()));
    chk("err_opcode", 32'(err_opcode), 32'(err));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("beats_accepted", 32'(acc_cnt), 32'(n));
  endtask

  task automatic set_beat(input int i, input logic [4:0] o, input logic [1:0] a,
                          input logic [1:0] b, input logic [7:0] l);
    b_opc[i] = o; b_op1[i] = a; b_op2[i] = b; b_lit[i] = l;
  endtask

  logic [4:0] vops[13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                           5'd16, 5'd17, 5'd18};

  initial begin
    vt[0]  = '{8'h20, 5'd1,  2'd2, 2'd1, 8'h00, 1'b1, 16'h0A08};
    vt[1]  = '{8'h21, 5'd9,  2'd3, 2'd0, 8'h5A, 1'b1, 16'h4B5A};
    vt[2]  = '{8'h22, 5'd5,  2'd1, 2'd3, 8'h00, 1'b1, 16'h2918};
    vt[3]  = '{8'h23, 5'd16, 2'd0, 2'd0, 8'h10, 1'b1, 16'h8010};
    vt[4]  = '{8'h24, 5'd0,  2'd3, 2'd3, 8'hFF, 1'b1, 16'h0000};
    vt[5]  = '{8'h25, 5'd2,  2'd1, 2'd2, 8'hFF, 1'b1, 16'h1110};
    vt[6]  = '{8'h26, 5'd8,  2'd2, 2'd3, 8'h0F, 1'b1, 16'h420F};
    vt[7]  = '{8'h27, 5'd18, 2'd1, 2'd3, 8'hA5, 1'b1, 16'h91A5};
    vt[8]  = '{8'h28, 5'd16, 2'd3, 2'd3, 8'h33, 1'b1, 16'h8033};
    vt[9]  = '{8'h29, 5'd6,  2'd3, 2'd3, 8'hFF, 1'b1, 16'h3318};
    vt[10] = '{8'h2A, 5'd10, 2'd1, 2'd1, 8'h11, 1'b0, 16'h0000};
    vt[11] = '{8'h2B, 5'd17, 2'd0, 2'd2, 8'h01, 1'b1, 16'h8801};
    vt[12] = '{8'h2C, 5'd7,  2'd1, 2'd2, 8'h80, 1'b1, 16'h3980};
    vt[13] = '{8'h2D, 5'd3,  2'd0, 2'd1, 8'h44, 1'b1, 16'h1808};
    vt[14] = '{8'h2E, 5'd4,  2'd2, 2'd0, 8'h00, 1'b1, 16'h2200};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);   chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
    chk("rst_mem_adr", 32'(mem_adr), 0);     chk("rst_mem_data", 32'(mem_data), 0);
    chk("rst_busy", 32'(busy), 0);           chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_opcode), 0);      chk("rst_overflow", 32'(overflow), 0);
    chk("rst_word_count", 32'(word_count), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Encoding table, one single-beat session per entry
    rdy_mode = 0;
    for (int i = 0; i < 15; i++) begin
      set_beat(0, vt[i].opc, vt[i].op1, vt[i].op2, vt[i].lit);
      run_session(vt[i].sa, 1, 1'b0);
      chk("tbl_nwrites", 32'(obs_data.size()), vt[i].ok ? 32'd1 : 32'd0);
      chk("tbl_err", 32'(err_opcode), 32'(!vt[i].ok));
      if (vt[i].ok && obs_data.size() > 0) begin
        chk("tbl_word", 32'(obs_data[0]), 32'(vt[i].w));
        chk("tbl_adr", 32'(obs_adr[0]), 32'(vt[i].sa));
      end
    end

    // Three-instruction program at consecutive addresses
    set_beat(0, 5'd9, 2'd3, 2'd0, 8'h5A);
    set_beat(1, 5'd5, 2'd1, 2'd3, 8'h00);
    set_beat(2, 5'd16, 2'd0, 2'd0, 8'h10);
    run_session(8'h30, 3, 1'b0);

    // Unsupported opcode between two NOPs
    set_beat(0, 5'd0, 2'd0, 2'd0, 8'h00);
    set_beat(1, 5'd10, 2'd2, 2'd1, 8'h77);
    set_beat(2, 5'd0, 2'd0, 2'd0, 8'h00);
    run_session(8'h60, 3, 1'b0);
    chk("badop_err", 32'(err_opcode), 1);
    chk("badop_writes", 32'(obs_data.size()), 2);

    // Address wrap: third word dropped after writing 8'hFF
    set_beat(0, 5'd1, 2'd1, 2'd1, 8'h00);
    set_beat(1, 5'd2, 2'd2, 2'd2, 8'h00);
    set_beat(2, 5'd3, 2'd3, 2'd3, 8'h00);
    run_session(8'hFE, 3, 1'b0);
    chk("wrap_overflow", 32'(overflow), 1);
    chk("wrap_word_count", 32'(word_count), 2);

    // Back-pressure: FIFO fills, outputs hold, then drain in order
    set_beat(0, 5'd9, 2'd3, 2'd0, 8'h5A);
    set_beat(1, 5'd5, 2'd1, 2'd3, 8'h00);
    set_beat(2, 5'd16, 2'd0, 2'd0, 8'h10);
    set_beat(3, 5'd1, 2'd2, 2'd1, 8'h00);
    set_beat(4, 5'd2, 2'd1, 2'd2, 8'h00);
    rdy_force = 1'b0; rdy_mode = 2;
    fork
      run_session(8'h40, 5, 1'b0);
      begin
        repeat (15) @(negedge clk);
        chk("bp_accepted", 32'(acc_cnt), 4);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_wr_en", 32'(mem_wr_en), 1);
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_adr", 32'(mem_adr), 32'h40);
          chk("bp_hold_data", 32'(mem_data), 32'h4B5A);
        end
        rdy_force = 1'b1;
      end
    join

    // Reset mid-session with two words queued; a stray start is ignored
    rdy_force = 1'b0;
    set_beat(0, 5'd4, 2'd1, 2'd1, 8'h00);
    set_beat(1, 5'd6, 2'd2, 2'd2, 8'h00);
    @(posedge clk); #1;
    start = 1'b1; start_adr = 8'h50;
    @(posedge clk); #1;
    start = 1'b0;
    drive_beat(0, 1'b0, 1'b0);
    drive_beat(1, 1'b0, 1'b0);
    start = 1'b1; start_adr = 8'h99;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("midrun_start_ignored", 32'(mem_adr), 32'h50);
    chk("midrun_wr_en", 32'(mem_wr_en), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rdy_force = 1'b1;
    @(negedge clk);
    chk("mrst_wr_en", 32'(mem_wr_en), 0);  chk("mrst_busy", 32'(busy), 0);
    chk("mrst_adr", 32'(mem_adr), 0);      chk("mrst_data", 32'(mem_data), 0);
    chk("mrst_in_ready", 32'(in_ready), 0); chk("mrst_wc", 32'(word_count), 0);
    obs_adr.delete(); obs_data.delete();
    repeat (10) @(negedge clk);
    chk("mrst_no_writes", 32'(obs_adr.size()), 0);

    // Randomized sessions with random mem_ready and input gaps
    rdy_mode = 1;
    repeat (25) begin
      int n;
      logic [7:0] sadr;
      n = $urandom_range(1, 8);
      sadr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255))
                                         : 8'($urandom_range(0, 255));
      for (int i = 0; i < n; i++) begin
        logic [4:0] o;
        o = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                        : vops[$urandom_range(0, 12)];
        set_beat(i, o, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)));
      end
      run_session(sadr, n, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- PROGRAM_DataWidth, 16, instruction word width
- PC_WIDTH, 8, program memory address width
- NumOpCodeBits, 5, opcode width
- SEL_WIDTH, 2, register select width
- FIFO_DEPTH, 4, encoded-word buffer entries
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin load session; sampled in IDLE only
- start_adr  in  8  first program address, captured on start
- in_valid  in  1  source presents an instruction
- in_ready  out  1  encoder accepts the instruction this cycle
- in_opcode  in  5  opcode field
- in_op1  in  2  destination/first register
- in_op2  in  2  second/source register
- in_literal  in  8  literal, jump target or shift amount
- in_last  in  1  qualifies the final instruction of the session
- mem_wr_en  out  1  program memory write request
- mem_ready  in  1  program memory accepts the write
- mem_adr  out  8  write address
- mem_data  out  16  encoded instruction word
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at session end
- err_opcode  out  1  sticky: unsupported opcode consumed
- overflow  out  1  sticky: address 8'hFF written, further words dropped
- word_count  out  9  words written this session

Function
REQ-003 Encoding SHALL place opcode in [15:11], op1 in [9:8], op2 in [4:3], literal in [7:0]; all unlisted bits zero.
REQ-004 NOP (00000) SHALL encode as 16'h0000.
REQ-005 ADD/SUB/AND/OR/NOT/XOR (00001-00110) SHALL encode opcode, op1 and op2.
REQ-006 SHL/SHR/VAL/IFZ/IFNZ (00111, 01000, 01001, 10001, 10010) SHALL encode opcode, op1 and literal.
REQ-007 GOTO (10000) SHALL encode opcode and literal.
REQ-008 All other opcodes SHALL be consumed, not enqueued, and set err_opcode.
REQ-009 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on start: load address pointer from start_adr; clear word_count, err_opcode and overflow.
- RUN -> DRAIN on an accepted beat with in_last=1.
- DRAIN -> DONE when the FIFO is empty.
- DONE -> IDLE after one cycle, with done=1 during DONE.
REQ-010 start outside IDLE SHALL be ignored.
REQ-011 in_ready SHALL be 1 only in RUN with the FIFO not full; there is no same-cycle enqueue when full.
REQ-012 An accepted beat (in_valid & in_ready) at edge N SHALL make its word available at the FIFO head no earlier than cycle N+1.
REQ-013 mem_wr_en SHALL equal FIFO-not-empty & !overflow; mem_adr and mem_data SHALL show the pointer and the FIFO head.
REQ-014 mem_adr and mem_data SHALL hold stable while mem_wr_en=1 and mem_ready=0.
REQ-015 A write completes on mem_wr_en & mem_ready: dequeue the word, increment the pointer modulo 256, and increment word_count.
REQ-016 A completed write to 8'hFF SHALL set overflow.
REQ-017 While overflow=1, FIFO entries SHALL be discarded one per cycle with mem_wr_en=0; accepted beats are still consumed.
REQ-018 When the FIFO is empty, mem_data SHALL be 16'h0000.
REQ-019 Simultaneous enqueue and dequeue SHALL keep the FIFO occupancy unchanged and preserve order.

Reset
REQ-020 On reset=1 the block SHALL enter IDLE and flush the FIFO.
REQ-021 On reset=1 the following SHALL be 0: in_ready, mem_wr_en, mem_adr, mem_data, busy, done, err_opcode, overflow and word_count.
REQ-022 Reset mid-session SHALL abandon the session with no further writes.

Verification
REQ-023 start, start_adr=8'h20; ADD op1=2 op2=1, last; mem_ready=1 -> one write of 16'h0A08 @8'h20, done pulse, word_count=1.
REQ-024 VAL op1=3 lit=8'h5A, NOT op1=1 op2=3, GOTO lit=8'h10 -> writes 16'h4B5A, 16'h2918, 16'h8010 @ consecutive addresses.
REQ-025 mem_ready=0 with 5 beats offered -> in_ready drops after 4 accepted; mem_adr and mem_data are held; on release the words drain in order.
REQ-026 opcode 5'b01010 between two NOPs -> err_opcode=1, two writes only.
REQ-027 start_adr=8'hFE, 3 beats -> writes @FE and @FF, overflow=1, third word dropped, word_count=2, done pulses.
REQ-028 reset asserted during RUN with 2 words queued -> next cycle IDLE, mem_wr_en=0, all outputs 0.
